// File: rtl/pattern_seq_pkg.sv
// rtl/pattern_seq_pkg.sv - shared state encoding and default parameters for pattern_seq
package pattern_seq_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } seq_state_t;

   localparam int DEF_CHANNELS = 4;
   localparam int DEF_PHASES   = 4;
   localparam int DEF_CNT_W    = 32;
endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - phase duration counter; tc marks the last cycle of a phase (len 0 acts as 1)
module phase_timer #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             enable,
   input  logic [CNT_W-1:0] len,
   output logic             tc
);
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] last;

   assign last = (len == '0) ? '0 : len - CNT_W'(1);
   assign tc   = (count == last);

   // Saturates at the terminal value so the count never wraps.
   always_ff @(posedge clk) begin
      if (reset || load)
         count <= '0;
      else if (enable && !tc)
         count <= count + CNT_W'(1);
   end
endmodule

// File: rtl/pattern_seq.sv
// rtl/pattern_seq.sv - multi-phase output pattern sequencer; optional pause via PATTERN_SEQ_PAUSE_EN
module pattern_seq
   import pattern_seq_pkg::*;
#(
   parameter int CHANNELS = DEF_CHANNELS,
   parameter int PHASES   = DEF_PHASES,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       stop,
   input  logic                       repeat_mode,
`ifdef PATTERN_SEQ_PAUSE_EN
   input  logic                       pause,
`endif
   input  logic [PHASES*CNT_W-1:0]    phase_len,
   input  logic [PHASES*CHANNELS-1:0] phase_pat,
   output logic [CHANNELS-1:0]        out,
   output logic                       busy,
   output logic                       done,
   output logic [$clog2(PHASES)-1:0]  phase_idx
);
   localparam int IDX_W = $clog2(PHASES);

   seq_state_t                 state, state_n;
   logic [PHASES*CNT_W-1:0]    len_r, len_n;
   logic [PHASES*CHANNELS-1:0] pat_r, pat_n;
   logic                       rpt_r, rpt_n;
   logic [CHANNELS-1:0]        out_n;
   logic [IDX_W-1:0]           idx_n;
   logic                       busy_n, done_n;
   logic                       timer_load, timer_en, timer_tc;
   logic [CNT_W-1:0]           cur_len;
   logic                       is_last;

   assign cur_len = len_r[phase_idx*CNT_W +: CNT_W];
   assign is_last = (phase_idx == IDX_W'(PHASES-1));

   phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk    (clk),
      .reset  (reset),
      .load   (timer_load),
      .enable (timer_en),
      .len    (cur_len),
      .tc     (timer_tc)
   );

   always_comb begin
      state_n    = state;
      len_n      = len_r;
      pat_n      = pat_r;
      rpt_n      = rpt_r;
      out_n      = out;
      idx_n      = phase_idx;
      done_n     = 1'b0;
      timer_load = 1'b0;
      timer_en   = 1'b0;
      case (state)
         IDLE: begin
            timer_load = 1'b1;
            if (start && !stop) begin
               state_n = RUN;
               len_n   = phase_len;
               pat_n   = phase_pat;
               rpt_n   = repeat_mode;
               idx_n   = '0;
               out_n   = phase_pat[CHANNELS-1:0];
            end
         end
         default: begin
            if (stop) begin
               state_n    = IDLE;
               out_n      = '0;
               idx_n      = '0;
               timer_load = 1'b1;
            end
`ifdef PATTERN_SEQ_PAUSE_EN
            else if (pause) begin
               state_n = PAUSE;
            end
`endif
            else begin
               state_n = RUN;
               if (!timer_tc) begin
                  timer_en = 1'b1;
               end else begin
                  // Next phase pattern is loaded on the same edge, so phases abut.
                  timer_load = 1'b1;
                  if (!is_last) begin
                     idx_n = phase_idx + IDX_W'(1);
                     out_n = pat_r[idx_n*CHANNELS +: CHANNELS];
                  end else if (rpt_r) begin
                     idx_n = '0;
                     out_n = pat_r[CHANNELS-1:0];
                  end else begin
                     state_n = IDLE;
                     idx_n   = '0;
                     out_n   = '0;
                     done_n  = 1'b1;
                  end
               end
            end
         end
      endcase
      busy_n = (state_n != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         len_r     <= '0;
         pat_r     <= '0;
         rpt_r     <= 1'b0;
         out       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         phase_idx <= '0;
      end else begin
         state     <= state_n;
         len_r     <= len_n;
         pat_r     <= pat_n;
         rpt_r     <= rpt_n;
         out       <= out_n;
         busy      <= busy_n;
         done      <= done_n;
         phase_idx <= idx_n;
      end
   end
endmodule

// File: tb/tb_pattern_seq.sv
// tb/tb_pattern_seq.sv - scoreboard bench for pattern_seq (pause test when PATTERN_SEQ_PAUSE_EN)
module tb_pattern_seq;
   typedef struct {
      string      tag;
      logic [3:0] o;
      logic       b;
      logic       d;
      logic [1:0] i;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset, start, stop, repeat_mode;
   logic         pause;
   logic [127:0] phase_len;
   logic [15:0]  phase_pat;
   logic [3:0]   out;
   logic         busy, done;
   logic [1:0]   phase_idx;

   exp_t sb[$];
   int   total  = 0;
   int   passed = 0;

   // Reference waveform for len {3,1,2,4}, pat {1,2,4,8}.
   logic [3:0] ref_out [10] = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd4, 4'd4, 4'd8, 4'd8, 4'd8, 4'd8};
   logic [1:0] ref_idx [10] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

   pattern_seq dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .stop        (stop),
      .repeat_mode (repeat_mode),
`ifdef PATTERN_SEQ_PAUSE_EN
      .pause       (pause),
`endif
      .phase_len   (phase_len),
      .phase_pat   (phase_pat),
      .out         (out),
      .busy        (busy),
      .done        (done),
      .phase_idx   (phase_idx)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      assert (act === exp) passed = passed + 1;
      else $error("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   task automatic push(input string tag, input logic [3:0] o, input logic b,
                       input logic d, input logic [1:0] i);
      exp_t e;
      e.tag = tag; e.o = o; e.b = b; e.d = d; e.i = i;
      sb.push_back(e);
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         total = total + 1;
         $error("FAIL scoreboard: empty queue got 0 expected 1");
      end else begin
         e = sb.pop_front();
         chk({e.tag, "_out"},  32'(out),       32'(e.o));
         chk({e.tag, "_busy"}, 32'(busy),      32'(e.b));
         chk({e.tag, "_done"}, 32'(done),      32'(e.d));
         chk({e.tag, "_idx"},  32'(phase_idx), 32'(e.i));
      end
   endtask

   task automatic set_cfg(input int l0, input int l1, input int l2, input int l3, input logic r);
      phase_len   = {32'(l3), 32'(l2), 32'(l1), 32'(l0)};
      phase_pat   = {4'd8, 4'd4, 4'd2, 4'd1};
      repeat_mode = r;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
      set_cfg(3, 1, 2, 4, 1'b0);
      push("reset", 4'd0, 1'b0, 1'b0, 2'd0); tick();
      push("reset", 4'd0, 1'b0, 1'b0, 2'd0); tick();
      reset = 1'b0;

      // One-shot, with start re-asserted and config scrambled mid-run
      start = 1'b1;
      push("oneshot", ref_out[0], 1'b1, 1'b0, ref_idx[0]); tick();
      phase_pat = '1; phase_len = '0; repeat_mode = 1'b1;
      for (int k = 1; k < 10; k++) begin
         push("oneshot", ref_out[k], 1'b1, 1'b0, ref_idx[k]); tick();
      end
      start = 1'b0;
      set_cfg(3, 1, 2, 4, 1'b0);
      push("oneshot_done", 4'd0, 1'b0, 1'b1, 2'd0); tick();
      push("oneshot_after", 4'd0, 1'b0, 1'b0, 2'd0); tick();

      // Repeat: 25 cycles of back-to-back wrapping, then stop
      set_cfg(3, 1, 2, 4, 1'b1);
      start = 1'b1;
      for (int k = 0; k < 25; k++) begin
         push("repeat", ref_out[k % 10], 1'b1, 1'b0, ref_idx[k % 10]); tick();
         start = 1'b0;
      end
      stop = 1'b1;
      push("repeat_stop", 4'd0, 1'b0, 1'b0, 2'd0); tick();
      stop = 1'b0;

      // Zero lengths behave as one cycle each
      set_cfg(0, 0, 0, 0, 1'b0);
      start = 1'b1;
      for (int k = 0; k < 4; k++) begin
         push("zerolen", 4'(1 << k), 1'b1, 1'b0, 2'(k)); tick();
         start = 1'b0;
      end
      push("zerolen_done", 4'd0, 1'b0, 1'b1, 2'd0); tick();

      // Stop on the second cycle of phase 2
      set_cfg(3, 1, 2, 4, 1'b0);
      start = 1'b1;
      for (int k = 0; k < 6; k++) begin
         push("stop", ref_out[k], 1'b1, 1'b0, ref_idx[k]); tick();
         start = 1'b0;
      end
      stop = 1'b1;
      push("stop_idle", 4'd0, 1'b0, 1'b0, 2'd0); tick();
      stop = 1'b0;
      push("stop_nodone", 4'd0, 1'b0, 1'b0, 2'd0); tick();

      // start and stop together in IDLE
      start = 1'b1; stop = 1'b1;
      push("startstop", 4'd0, 1'b0, 1'b0, 2'd0); tick();
      push("startstop", 4'd0, 1'b0, 1'b0, 2'd0); tick();
      start = 1'b0; stop = 1'b0;

      // Reset during phase 1, then a fresh start
      start = 1'b1;
      for (int k = 0; k < 4; k++) begin
         push("rst_mid", ref_out[k], 1'b1, 1'b0, ref_idx[k]); tick();
         start = 1'b0;
      end
      reset = 1'b1; start = 1'b1; stop = 1'b1;
      push("rst_mid_reset", 4'd0, 1'b0, 1'b0, 2'd0); tick();
      reset = 1'b0; stop = 1'b0;
      for (int k = 0; k < 4; k++) begin
         push("rst_restart", ref_out[k], 1'b1, 1'b0, ref_idx[k]); tick();
         start = 1'b0;
      end
      stop = 1'b1;
      push("rst_restart_stop", 4'd0, 1'b0, 1'b0, 2'd0); tick();
      stop = 1'b0;

`ifdef PATTERN_SEQ_PAUSE_EN
      // Pause five cycles in phase 1: phase 1 lasts 1+5 cycles
      start = 1'b1;
      for (int k = 0; k < 4; k++) begin
         push("pause", ref_out[k], 1'b1, 1'b0, ref_idx[k]); tick();
         start = 1'b0;
      end
      pause = 1'b1;
      for (int k = 0; k < 5; k++) begin
         push("pause_hold", 4'd2, 1'b1, 1'b0, 2'd1); tick();
      end
      pause = 1'b0;
      for (int k = 4; k < 10; k++) begin
         push("pause_resume", ref_out[k], 1'b1, 1'b0, ref_idx[k]); tick();
      end
      push("pause_done", 4'd0, 1'b0, 1'b1, 2'd0); tick();

      // Stop while paused
      start = 1'b1;
      push("pstop", 4'd1, 1'b1, 1'b0, 2'd0); tick();
      start = 1'b0; pause = 1'b1;
      push("pstop_hold", 4'd1, 1'b1, 1'b0, 2'd0); tick();
      stop = 1'b1;
      push("pstop_idle", 4'd0, 1'b0, 1'b0, 2'd0); tick();
      stop = 1'b0; pause = 1'b0;
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
